// File: rtl/jk_bank_driver_if.sv
// Bus between the JK bank driver and its requester / flop bank.
// The slave modport is the driver; the master modport is the requester plus the bank.
interface jk_bank_driver_if #(parameter int W = 8);
  logic         start;
  logic [W-1:0] target;
  logic [W-1:0] q_fb;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic         ready;
  logic         done;
  logic         err;

  modport master (output start, target, q_fb, input j, k, ready, done, err);
  modport slave  (input start, target, q_fb, output j, k, ready, done, err);
endinterface

// File: rtl/jk_bank_driver.sv
// Drives J/K of a W-bit JK flop bank toward a requested word using the excitation table.
// Optional read-back verify with retries is enabled by defining JK_DRV_VERIFY_EN.
module jk_exc_lane (
  input  logic q,
  input  logic t,
  output logic j,
  output logic k
);
  // Set or clear only; toggle (j=k=1) is never produced.
  assign j = ~q &  t;
  assign k =  q & ~t;
endmodule

module jk_bank_driver #(
  parameter int W         = 8,
  parameter int MAX_RETRY = 3
) (
  input logic             clk,
  input logic             reset,
  jk_bank_driver_if.slave bus
);

  if (MAX_RETRY < 0 || MAX_RETRY > 15) begin : g_bad_retry
    $error("jk_bank_driver: MAX_RETRY must be 0..15");
  end

`ifdef JK_DRV_VERIFY_EN
  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE} state_t;
`endif

  state_t       state, nstate;
  logic [W-1:0] tgt_r, tgt_nx;
  logic [W-1:0] exc_j, exc_k;
  logic [W-1:0] j_q, k_q, j_d, k_d;
  logic         ready_q, ready_d;
  logic         done_q, done_d;
  logic         accept;

`ifdef JK_DRV_VERIFY_EN
  logic [3:0] rcnt, rcnt_d;
  logic       err_q, err_d;
  logic       match, exhausted;
  assign match     = (bus.q_fb == tgt_r);
  assign exhausted = (rcnt == 4'(MAX_RETRY));
`endif

  assign accept = (state == IDLE) && bus.start;
  // j/k are registered, so the excitation is computed one cycle early; the
  // bank holds during that cycle (j=k=0), so q_fb equals its DRIVE-cycle value.
  assign tgt_nx = (state == IDLE) ? bus.target : tgt_r;

  for (genvar gi = 0; gi < W; gi++) begin : g_lane
    jk_exc_lane u_lane (
      .q (bus.q_fb[gi]),
      .t (tgt_nx[gi]),
      .j (exc_j[gi]),
      .k (exc_k[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tgt_r   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
`ifdef JK_DRV_VERIFY_EN
      rcnt    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state   <= nstate;
      tgt_r   <= tgt_nx;
      j_q     <= j_d;
      k_q     <= k_d;
      ready_q <= ready_d;
      done_q  <= done_d;
`ifdef JK_DRV_VERIFY_EN
      rcnt    <= rcnt_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:   if (bus.start) nstate = DRIVE;
      DRIVE:  nstate = SETTLE;
`ifdef JK_DRV_VERIFY_EN
      SETTLE: nstate = CHECK;
      CHECK:  nstate = (match || exhausted) ? IDLE : DRIVE;
`else
      SETTLE: nstate = IDLE;
`endif
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    j_d     = (nstate == DRIVE) ? exc_j : '0;
    k_d     = (nstate == DRIVE) ? exc_k : '0;
    ready_d = (nstate == IDLE);
    done_d  = (state != IDLE) && (nstate == IDLE);
`ifdef JK_DRV_VERIFY_EN
    rcnt_d  = rcnt;
    err_d   = err_q;
    if (accept) begin
      rcnt_d = '0;
      err_d  = 1'b0;
    end else if (state == CHECK && !match) begin
      if (exhausted) err_d  = 1'b1;
      else           rcnt_d = rcnt + 4'd1;
    end
`endif
  end

  assign bus.j     = j_q;
  assign bus.k     = k_q;
  assign bus.ready = ready_q;
  assign bus.done  = done_q;
`ifdef JK_DRV_VERIFY_EN
  assign bus.err   = err_q;
`else
  assign bus.err   = 1'b0;
`endif

endmodule

// File: tb/tb_jk_bank_driver.sv
// Scoreboard bench: a JK flop bank closes the loop; expectations come from the target word alone.
module tb_jk_bank_driver;
  localparam int W  = 8;
  localparam int MR = 3;
`ifdef JK_DRV_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  jk_bank_driver_if #(.W(W)) bus ();
  jk_bank_driver #(.W(W), .MAX_RETRY(MR)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Flop bank: Q+ = J&~Q | ~K&Q, with an optional stuck-at-0 read-back mask.
  logic [W-1:0] bank, stuck;
  always_ff @(posedge clk) begin
    if (reset) bank <= '0;
    else       bank <= (bus.j & ~bank) | (~bus.k & bank);
  end
  assign bus.q_fb = bank & ~stuck;

  typedef struct {
    logic [W-1:0] j, k, q;
    bit           err;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           tests = 0, fails = 0;
  logic [W-1:0] mbank = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // Monitor: tracks cycles from acceptance, checks the first drive and every completion.
  int cyc = 0;
  bit busy = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sb.delete();
      busy = 0;
    end else begin
      if (busy) cyc++;
      chk("jk_excl", bus.j & bus.k, 0);
      if (busy && cyc == 1 && sb.size() > 0) begin
        chk("drive_j", bus.j, sb[0].j);
        chk("drive_k", bus.k, sb[0].k);
      end
      if (busy && cyc > 100) begin
        chk("timeout", 1, 0);
        busy = 0;
      end
      if (bus.done) begin
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("bank", bus.q_fb, e.q);
          chk("err", bus.err, e.err);
          chk("latency", cyc, e.lat);
          chk("ready_with_done", bus.ready, 1);
        end
        busy = 0;
      end
      if (bus.start && bus.ready) begin
        busy = 1;
        cyc  = 0;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("wait_ready", 0, 1);
  endtask

  function automatic exp_t model(input logic [W-1:0] t);
    exp_t e;
    logic [W-1:0] qv;
    bit match;
    qv    = mbank & ~stuck;
    e.j   = t & ~qv;
    e.k   = ~t & qv;
    e.q   = t & ~stuck;
    match = (e.q == t);
    e.err = VER && !match;
    e.lat = !VER ? 3 : (match ? 4 : 4 + 3 * MR);
    return e;
  endfunction

  // Called at posedge+1 with ready=1; leaves at posedge+1 of the third edge.
  task automatic issue(input logic [W-1:0] t, input bit noise);
    sb.push_back(model(t));
    mbank      = t;
    bus.start  = 1'b1;
    bus.target = t;
    @(posedge clk); #1;
    bus.target = W'($urandom);
    bus.start  = noise ? 1'($urandom) : 1'b0;
    @(posedge clk); #1;
    bus.start  = noise ? 1'($urandom) : 1'b0;
    @(posedge clk); #1;
    bus.start  = 1'b0;
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.target = '0;
    stuck      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_j", bus.j, 0);
    chk("rst_k", bus.k, 0);
    chk("rst_ready", bus.ready, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_bank", bus.q_fb, 0);
    reset = 1'b0;

    wait_ready(); issue(8'hA5, 1'b0);
    wait_ready(); issue(8'h5A, 1'b1);
    wait_ready(); issue(8'h5A, 1'b0);

    // Stuck read-back bit: retries, then sticky err until the next start.
    wait_ready();
    stuck = 8'h01;
    issue(8'h01, 1'b0);
    wait_ready();
    @(posedge clk); #1;
    chk("err_sticky", bus.err, VER);
    stuck = '0;
    wait_ready(); issue(W'($urandom), 1'b0);

    // Reset during SETTLE with start pulses in DRIVE and SETTLE.
    wait_ready();
    sb.push_back(model(8'h3C));
    bus.start  = 1'b1;
    bus.target = 8'h3C;
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b1;
    reset     = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready", bus.ready, 1);
    chk("midrst_j", bus.j, 0);
    chk("midrst_k", bus.k, 0);
    chk("midrst_done", bus.done, 0);
    bus.start = 1'b0;
    reset     = 1'b0;
    mbank     = '0;

    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      wait_ready();
      issue(W'($urandom), 1'($urandom));
    end

    wait_ready();
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
